// File: rtl/parking_pkg.sv
// Shared constants and types for the parking lift scheduler.
// Holds the slot geometry, lift timing, the controller state enum and
// the operation enum that also serves as the round-robin priority token.
package parking_pkg;

    localparam int unsigned NUM_SLOTS   = 24;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned MOVE_CYCLES = 8;
    localparam int unsigned HOLD_CYCLES = 4;

    // One counter serves both lift stepping and load/unload hold time
    localparam int unsigned CNT_MAX = (MOVE_CYCLES > HOLD_CYCLES) ? MOVE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_OUT  = 3'd1,
        XFER      = 3'd2,
        MOVE_BACK = 3'd3,
        DONE      = 3'd4
    } state_e;

    typedef enum logic {
        PARK = 1'b0,
        RETR = 1'b1
    } op_e;

endpackage

// File: rtl/parking_lift_scheduler_free_slot_finder.sv
// Lowest-free-slot priority encoder over the occupancy map.
// Ports:
//   occ_i   - occupancy map, bit i=1 means slot i occupied
//   slot_o  - index of the lowest clear bit (0 when none)
//   valid_o - at least one slot is free
module free_slot_finder
    import parking_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] occ_i,
    output logic [ADDR_W-1:0]    slot_o,
    output logic                 valid_o
);

    // Scan from the top so the lowest free index is the last one written
    always_comb begin
        slot_o  = '0;
        valid_o = 1'b0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!occ_i[i]) begin
                slot_o  = ADDR_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_lift_scheduler.sv
// Single-lift sequencer for the automated parking lot.
// Arbitrates park/retrieve requests (round-robin when both are eligible),
// moves the lift one position per MOVE_CYCLES, loads/unloads in HOLD_CYCLES
// and owns the occupancy map.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   park_req/park_ack  - gate park request (level) / completion pulse
//   retr_req/retr_ack  - retrieve request (level) / completion-or-reject pulse
//   retr_addr          - slot to retrieve, sampled at grant
//   err                - pulses with retr_ack on a rejected retrieve
//   car_storage        - occupancy map
//   lift_pos           - lift position, 0 = gate
//   busy               - controller not idle
//   full               - combinational, all slots occupied
module parking_lift_scheduler
    import parking_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 park_req,
    output logic                 park_ack,
    input  logic                 retr_req,
    input  logic [ADDR_W-1:0]    retr_addr,
    output logic                 retr_ack,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] car_storage,
    output logic [ADDR_W-1:0]    lift_pos,
    output logic                 busy,
    output logic                 full
);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    op_e                   prio_q, prio_d;
    logic [ADDR_W-1:0]     target_q, target_d;
    logic [ADDR_W-1:0]     pos_q, pos_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]  map_q, map_d;
    logic                  park_ack_q, park_ack_d;
    logic                  retr_ack_q, retr_ack_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic [ADDR_W-1:0]     free_slot;
    logic                  free_valid;
    logic                  park_elig, retr_elig, grant_retr, grant_park;
    logic                  addr_ok, slot_occ;

    free_slot_finder u_finder (
        .occ_i   (map_q),
        .slot_o  (free_slot),
        .valid_o (free_valid)
    );

    // A request being acked this cycle is still held high by its requester;
    // masking it prevents a spurious re-grant.
    assign park_elig  = park_req && free_valid && !park_ack_q;
    assign retr_elig  = retr_req && !retr_ack_q;
    assign grant_retr = retr_elig && (!park_elig || (prio_q == RETR));
    assign grant_park = park_elig && !grant_retr;
    assign addr_ok    = retr_addr < ADDR_W'(NUM_SLOTS);
    assign slot_occ   = addr_ok && map_q[retr_addr];

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        prio_d     = prio_q;
        target_d   = target_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        map_d      = map_q;
        park_ack_d = 1'b0;
        retr_ack_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_retr) begin
                    if (!slot_occ) begin
                        // Rejected: answer at once, keep priority unchanged
                        retr_ack_d = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        target_d = retr_addr;
                        op_d     = RETR;
                        state_d  = MOVE_OUT;
                        if (park_elig) prio_d = PARK;
                    end
                end else if (grant_park) begin
                    target_d = free_slot;
                    op_d     = PARK;
                    state_d  = MOVE_OUT;
                    if (retr_elig) prio_d = RETR;
                end
            end
            MOVE_OUT: begin
                if (cnt_q == CNT_W'(MOVE_CYCLES - 1)) begin
                    cnt_d = '0;
                    pos_d = pos_q + ADDR_W'(1);
                    // Slot target sits at position target+1
                    if (pos_q == target_q) state_d = XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            XFER: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt_d           = '0;
                    map_d[target_q] = (op_q == PARK);
                    state_d         = MOVE_BACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MOVE_BACK: begin
                if (cnt_q == CNT_W'(MOVE_CYCLES - 1)) begin
                    cnt_d = '0;
                    pos_d = pos_q - ADDR_W'(1);
                    if (pos_q == ADDR_W'(1)) state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                park_ack_d = (op_q == PARK);
                retr_ack_d = (op_q == RETR);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= PARK;
            prio_q     <= RETR;
            target_q   <= '0;
            pos_q      <= '0;
            cnt_q      <= '0;
            map_q      <= '0;
            park_ack_q <= 1'b0;
            retr_ack_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            prio_q     <= prio_d;
            target_q   <= target_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            map_q      <= map_d;
            park_ack_q <= park_ack_d;
            retr_ack_q <= retr_ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign park_ack    = park_ack_q;
    assign retr_ack    = retr_ack_q;
    assign err         = err_q;
    assign car_storage = map_q;
    assign lift_pos    = pos_q;
    assign busy        = busy_q;
    assign full        = &map_q;

endmodule
